// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter driving a registered 2:1 mux output slot
// with valid/ready handshakes on both sides and per-requester grant counters.
module mux_arbiter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    output logic              sel_o,
    output logic              y_valid_o,
    output logic [DATA_W-1:0] y_data_o,
    input  logic              y_ready_i,
    output logic [CNT_W-1:0]  a_cnt_o,
    output logic [CNT_W-1:0]  b_cnt_o
);

    logic              y_valid_q, y_valid_d;
    logic [DATA_W-1:0] y_data_q, y_data_d;
    logic [CNT_W-1:0]  a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0]  b_cnt_q, b_cnt_d;
    logic              last_sel_q, last_sel_d;   // 1 = B won last, so A wins next tie
    logic              accept_en;
    logic              gnt_a, gnt_b;
    logic              xfer_a, xfer_b;

    // Grant: lone requester wins; on contention the one not served last wins.
    always_comb begin
        accept_en = !y_valid_q || y_ready_i;
        gnt_a     = a_valid_i && (!b_valid_i || last_sel_q);
        gnt_b     = b_valid_i && (!a_valid_i || !last_sel_q);
        sel_o     = (a_valid_i || b_valid_i) ? gnt_b : last_sel_q;
        // Readies are forced low while reset is held, even though the slot reads empty.
        a_ready_o = reset_n_i && accept_en && gnt_a;
        b_ready_o = reset_n_i && accept_en && gnt_b;
        xfer_a    = a_valid_i && a_ready_o;
        xfer_b    = b_valid_i && b_ready_o;
    end

    // Next state: load slot on a transfer, otherwise empty it once drained.
    always_comb begin
        y_valid_d  = y_valid_q;
        y_data_d   = y_data_q;
        a_cnt_d    = a_cnt_q;
        b_cnt_d    = b_cnt_q;
        last_sel_d = last_sel_q;
        if (xfer_a || xfer_b) begin
            y_valid_d  = 1'b1;
            y_data_d   = sel_o ? b_data_i : a_data_i;
            last_sel_d = sel_o;
            if (xfer_a) a_cnt_d = a_cnt_q + 1'b1;
            if (xfer_b) b_cnt_d = b_cnt_q + 1'b1;
        end else if (y_ready_i) begin
            y_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any held word immediately.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            y_valid_q  <= 1'b0;
            y_data_q   <= '0;
            a_cnt_q    <= '0;
            b_cnt_q    <= '0;
            last_sel_q <= 1'b1;
        end else begin
            y_valid_q  <= y_valid_d;
            y_data_q   <= y_data_d;
            a_cnt_q    <= a_cnt_d;
            b_cnt_q    <= b_cnt_d;
            last_sel_q <= last_sel_d;
        end
    end

    assign y_valid_o = y_valid_q;
    assign y_data_o  = y_data_q;
    assign a_cnt_o   = a_cnt_q;
    assign b_cnt_o   = b_cnt_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: the driver predicts handshakes from the
// arbitration rules and queues expected words; a monitor checks deliveries.
module tb_mux_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_valid, b_valid, y_ready;
    logic [7:0]  a_data, b_data;
    logic        a_ready, b_ready, sel, y_valid;
    logic [7:0]  y_data;
    logic [15:0] a_cnt, b_cnt;

    int errors = 0;
    int checks = 0;

    // Reference state: what the output slot holds and who was served last.
    logic [7:0] exp_q[$];
    bit         m_occ;
    bit         m_lastB;
    logic [7:0] m_ydata;
    int         m_acnt, m_bcnt;

    mux_arbiter #(.DATA_W(8), .CNT_W(16)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .a_valid_i(a_valid), .a_data_i(a_data), .a_ready_o(a_ready),
        .b_valid_i(b_valid), .b_data_i(b_data), .b_ready_o(b_ready),
        .sel_o(sel), .y_valid_o(y_valid), .y_data_o(y_data), .y_ready_i(y_ready),
        .a_cnt_o(a_cnt), .b_cnt_o(b_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_occ   = 1'b0;
        m_lastB = 1'b1;
        m_ydata = 8'h00;
        m_acnt  = 0;
        m_bcnt  = 0;
    endtask

    // One clock cycle of stimulus: drive, check combinational/registered
    // outputs against the reference, then advance the reference.
    task automatic cycle(input bit av, input logic [7:0] ad, input bit bv,
                         input logic [7:0] bd, input bit yr);
        bit free, any, winB, ea, eb;
        @(negedge clk);
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
        #1;
        free = !m_occ || yr;
        any  = av || bv;
        winB = (av && bv) ? !m_lastB : bv;
        ea   = free && any && !winB;
        eb   = free && any && winB;
        chk("a_ready", a_ready, ea);
        chk("b_ready", b_ready, eb);
        chk("sel", sel, any ? winB : m_lastB);
        chk("y_valid", y_valid, m_occ);
        chk("y_data", y_data, m_ydata);
        chk("a_cnt", a_cnt, m_acnt);
        chk("b_cnt", b_cnt, m_bcnt);
        if (ea || eb) begin
            m_ydata = winB ? bd : ad;
            exp_q.push_back(m_ydata);
            m_occ   = 1'b1;
            m_lastB = winB;
            if (winB) m_bcnt = (m_bcnt + 1) % 65536;
            else      m_acnt = (m_acnt + 1) % 65536;
        end else if (yr) begin
            m_occ = 1'b0;
        end
    endtask

    // Monitor: a delivery occurs whenever the slot is valid and downstream is ready.
    always begin
        @(negedge clk);
        #2;
        if (reset_n && y_valid && y_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL deliver: got %0h expected no word", y_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (y_data != e) begin
                    errors++;
                    $display("FAIL deliver: got %0h expected %0h at %0t", y_data, e, $time);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        a_valid = 1'b1; a_data = 8'h77; b_valid = 1'b1; b_data = 8'h66; y_ready = 1'b1;
        model_reset();
        #1;
        chk("rst y_valid", y_valid, 0);
        chk("rst y_data", y_data, 0);
        chk("rst a_cnt", a_cnt, 0);
        chk("rst b_cnt", b_cnt, 0);
        chk("rst a_ready", a_ready, 0);
        chk("rst b_ready", b_ready, 0);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        #2 reset_n = 1'b1;

        // Single A transfer with one-cycle latency.
        cycle(1, 8'h3C, 0, 8'h00, 1);
        cycle(0, 8'h00, 0, 8'h00, 1);
        chk("lat a_cnt", a_cnt, 1);
        cycle(0, 8'h00, 0, 8'h00, 1);

        // Continuous contention alternates A, B, A, B...
        for (int i = 0; i < 8; i++) cycle(1, 8'h11, 1, 8'h22, 1);
        cycle(0, 8'h00, 0, 8'h00, 1);
        chk("rr counts equal", a_cnt - 16'd1, b_cnt);

        // Stall holding AA, then round-robin resumes from last winner.
        cycle(0, 8'h00, 0, 8'h00, 1);
        cycle(1, 8'hAA, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) cycle(1, 8'h11, 1, 8'h22, 0);
        chk("stall hold", y_data, 8'hAA);
        cycle(1, 8'h11, 1, 8'h22, 1);
        cycle(0, 8'h00, 0, 8'h00, 1);
        cycle(0, 8'h00, 0, 8'h00, 1);

        // Only B for 4 cycles.
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 8'hB0 + 8'(i), 1);
        cycle(0, 8'h00, 0, 8'h00, 1);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1),
                  8'($urandom), ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 8'h00, 1);

        // Async reset mid-stall discards the held word.
        cycle(1, 8'hAA, 0, 8'h00, 1);
        cycle(1, 8'h11, 1, 8'h22, 0);
        #3 reset_n = 1'b0;
        #1;
        chk("async y_valid", y_valid, 0);
        chk("async y_data", y_data, 0);
        chk("async a_cnt", a_cnt, 0);
        chk("async a_ready", a_ready, 0);
        chk("async b_ready", b_ready, 0);
        model_reset();
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
        #3 reset_n = 1'b1;
        cycle(1, 8'h55, 0, 8'h00, 1);
        cycle(0, 8'h00, 0, 8'h00, 1);
        chk("post-rst data", y_data, 8'h55);

        // Counter wrap: from 1 up to 65535, then one more wraps to 0.
        for (int i = 0; i < 65534; i++) cycle(1, 8'(i), 0, 8'h00, 1);
        cycle(0, 8'h00, 0, 8'h00, 1);
        chk("a_cnt max", a_cnt, 16'hFFFF);
        cycle(1, 8'h99, 0, 8'h00, 1);
        cycle(0, 8'h00, 0, 8'h00, 1);
        chk("a_cnt wrap", a_cnt, 0);
        cycle(0, 8'h00, 0, 8'h00, 1);
        chk("queue drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
